fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch unit (PC register + instruction ROM) and decode.
//  Captures {PC, Instr} pairs produced by fetch and holds them in a small circular FIFO.
//  Presents them to decode with valid/ready handshakes, so decode stalls back-pressure fetch.
//  Flush discards all buffered instructions on a branch/jump redirect.
// PARAMETERS
//  DEPTH     4             entries; power of two, >= 2
//  PTR_W     2             log2(DEPTH); pointer width
//  NOP_INSTR 32'h00000000  D_Instr value driven while empty
// PORTS
//  clk       in   1        system clock, all state updates on posedge
//  reset     in   1        synchronous, active-high
//  F_PC      in   32       PC of fetched instruction (0x00003000-based)
//  F_Instr   in   32       fetched instruction word
//  F_valid   in   1        fetch offers {F_PC, F_Instr} this cycle
//  F_ready   out  1        queue accepts; = !full
//  D_valid   out  1        head entry valid; = !empty
//  D_ready   in   1        decode consumes head this cycle
//  D_PC      out  32       head PC; 32'h0 when empty
//  D_Instr   out  32       head instruction; NOP_INSTR when empty
//  flush     in   1        discard all entries (redirect)
//  count     out  PTR_W+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - push = F_valid & F_ready; pop = D_valid & D_ready; both evaluated on the same edge.
//  - Reset (sync): wr_ptr = rd_ptr = 0, count = 0.
//    -> F_ready = 1, D_valid = 0, D_PC = 0, D_Instr = NOP_INSTR.
//    Storage array is not cleared.
//  - Push writes mem[wr_ptr] <= {F_PC, F_Instr}; wr_ptr <= wr_ptr + 1 mod DEPTH.
//  - Pop: rd_ptr <= rd_ptr + 1 mod DEPTH; no data movement.
//  - Head outputs are combinational reads of mem[rd_ptr], gated by !empty.
//    Push-to-visible latency is 1 cycle; there is no empty bypass.
//  - count: +1 on push only, -1 on pop only, unchanged on push & pop together.
//  - full = (count == DEPTH); empty = (count == 0).
//  - Full: F_ready = 0, even if pop is asserted that cycle; F_valid is ignored.
//  - Empty: D_ready is ignored; pointers and count are unchanged.
//  - Pointers wrap modulo DEPTH; only count distinguishes full from empty when wr_ptr == rd_ptr.
//  - Flush: next edge wr_ptr = rd_ptr = 0 and count = 0.
//    Flush has priority over a same-cycle push and pop; neither takes effect.
//    F_ready is still driven from the current count during the flush cycle.
//  - Reset has priority over flush. Reset mid-stream drops all entries identically to flush.
//  - Upstream contract: F_PC/F_Instr are held stable while F_valid & !F_ready.
//    The fetch PC register does not advance without a push.
// STRUCTURE
//  - Shared header (const.v): `NOP 32'h0, `PC_RESET 32'h00003000, `INSTR_W 32.
//    Same constants as fetch and decode use.
//  - Sub-module fetch_queue_mem: DEPTH x 64 array.
//    One sync write port, one async read port; no reset.
//  - Top holds pointers, count, handshake and flush logic only.
// TESTING
//  1. Reset, then push PC=0x3000 Instr=0x34010001 with D_ready=0.
//     -> next cycle D_valid=1, D_PC=0x3000, D_Instr=0x34010001, count=1.
//  2. Push 4 entries (0x3000..0x300C), D_ready=0.
//     -> count=4, F_ready=0; a 5th F_valid is ignored, count stays 4.
//  3. Full queue, F_valid=1 and D_ready=1 for one cycle.
//     -> pop only: count=3, head=0x3004, F_ready=1 next cycle.
//  4. Count=2, push & pop every cycle for 10 cycles, PCs incrementing by 4.
//     -> count stays 2; PCs leave in order across pointer wrap, no loss or duplicate.
//  5. Count=3, assert flush together with F_valid=1 and D_ready=1.
//     -> next cycle count=0, D_valid=0, D_Instr=0, D_PC=0.
//  6. Count=2, assert reset and flush together.
//     -> reset state; then push 0x3000 -> visible after 1 cycle; old data never appears.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the fetch queue, matching fetch and decode.
package fetch_queue_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    // One buffered fetch result: PC in the upper half, instruction word in the lower half.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output fq_entry_t        rdata
);

    fq_entry_t mem [DEPTH];

    // Write the pushed entry; contents are deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with valid/ready on both sides
// and a flush that drops everything on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = 2,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        F_PC,
    input  logic [INSTR_W-1:0] F_Instr,
    input  logic               F_valid,
    output logic               F_ready,
    output logic               D_valid,
    input  logic               D_ready,
    output logic [31:0]        D_PC,
    output logic [INSTR_W-1:0] D_Instr,
    input  logic               flush,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CntOne  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, empty, push, pop;
    fq_entry_t        wr_entry, head;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    // Ready depends only on occupancy, so a same-cycle pop never opens a full queue.
    assign F_ready = !full;
    assign D_valid = !empty;
    assign push    = F_valid && F_ready && !flush;
    assign pop     = D_valid && D_ready && !flush;

    assign wr_entry = '{pc: F_PC, instr: F_Instr};

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // Head is a plain read of the storage, masked while empty (no write-to-read bypass).
    always_comb begin
        D_PC    = 32'h0;
        D_Instr = NOP_INSTR;
        if (!empty) begin
            D_PC    = head.pc;
            D_Instr = head.instr;
        end
    end

    // Next pointers and occupancy; flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic, all checked
// against a queue-based model of the buffer contents.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic        clk = 1'b0;
    logic        reset, F_valid, D_ready, flush;
    logic [31:0] F_PC, F_Instr;
    logic        F_ready, D_valid;
    logic [31:0] D_PC, D_Instr;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [63:0] model_q [$];
    logic [31:0] pc;
    logic [31:0] instr;
    bit          last_push;

    fetch_queue #(
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W),
        .NOP_INSTR (NOP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .F_PC    (F_PC),
        .F_Instr (F_Instr),
        .F_valid (F_valid),
        .F_ready (F_ready),
        .D_valid (D_valid),
        .D_ready (D_ready),
        .D_PC    (D_PC),
        .D_Instr (D_Instr),
        .flush   (flush),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check_outputs(input string tag);
        logic [2:0]  exp_cnt;
        logic        exp_fr, exp_dv;
        logic [31:0] exp_pc, exp_in;
        exp_cnt = 3'(model_q.size());
        exp_fr  = (model_q.size() < DEPTH);
        exp_dv  = (model_q.size() != 0);
        exp_pc  = exp_dv ? model_q[0][63:32] : 32'h0;
        exp_in  = exp_dv ? model_q[0][31:0]  : NOP;
        tests++;
        assert (count === exp_cnt) else begin
            fails++;
            $error("FAIL %s count got=%0d exp=%0d", tag, count, exp_cnt);
        end
        tests++;
        assert (F_ready === exp_fr) else begin
            fails++;
            $error("FAIL %s F_ready got=%b exp=%b", tag, F_ready, exp_fr);
        end
        tests++;
        assert (D_valid === exp_dv) else begin
            fails++;
            $error("FAIL %s D_valid got=%b exp=%b", tag, D_valid, exp_dv);
        end
        tests++;
        assert (D_PC === exp_pc) else begin
            fails++;
            $error("FAIL %s D_PC got=%h exp=%h", tag, D_PC, exp_pc);
        end
        tests++;
        assert (D_Instr === exp_in) else begin
            fails++;
            $error("FAIL %s D_Instr got=%h exp=%h", tag, D_Instr, exp_in);
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs on the falling edge, advance the model.
    task automatic step(input bit fv, input bit dr, input bit fl, input bit rst,
                        input string tag);
        bit do_pop, do_push;
        reset   = rst;
        flush   = fl;
        F_valid = fv;
        D_ready = dr;
        F_PC    = pc;
        F_Instr = instr;
        @(negedge clk);
        if (check_en) check_outputs(tag);
        last_push = 1'b0;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            do_pop  = dr && (model_q.size() != 0);
            do_push = fv && (model_q.size() < DEPTH);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, instr});
            last_push = do_push;
        end
        @(posedge clk);
        #1;
        // Fetch only advances its PC once the current offer has been taken.
        if (last_push) begin
            pc    = pc + 32'd4;
            instr = $urandom;
        end
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        F_valid = 1'b0;
        D_ready = 1'b0;
        pc      = PC_RESET;
        instr   = 32'h3401_0001;
        F_PC    = pc;
        F_Instr = instr;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b1, "init_reset");
        check_en = 1'b1;

        // 1: single push, visible one cycle later
        step(1'b1, 1'b0, 1'b0, 1'b0, "t1_push");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t1_visible");

        // 2: fill to full, extra offer ignored
        pc = PC_RESET;
        step(1'b0, 1'b0, 1'b0, 1'b1, "t2_reset");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "t2_fill");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t2_full_offer");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t2_still_full");

        // 3: full with push and pop offered -> pop only
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3_full_pp");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t3_after");

        // 4: steady push+pop at count 2 across pointer wrap
        step(1'b0, 1'b1, 1'b0, 1'b0, "t4_drain");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t4_stream");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t4_after");

        // 5: flush with push and pop at count 3
        step(1'b1, 1'b0, 1'b0, 1'b0, "t5_fill");
        step(1'b1, 1'b1, 1'b1, 1'b0, "t5_flush");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t5_after");

        // 6: reset and flush together at count 2, then fresh push
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_fill");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_fill");
        step(1'b0, 1'b0, 1'b1, 1'b1, "t6_rst_flush");
        pc = PC_RESET;
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_push");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t6_visible");

        // Random traffic with occasional redirects and resets
        for (int i = 0; i < 400; i++) begin
            bit fv, dr, fl, rs;
            fv = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(fv, dr, fl, rs, "rand");
            if (fl || rs) begin
                pc    = PC_RESET + ($urandom_range(0, 255) << 2);
                instr = $urandom;
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
